// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry registered between stages.
// Upper operand slices ride forward (skewed) while finished low result slices accumulate.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned Chunk = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Rem = operand bits still to be added, including this stage's slice
        localparam int unsigned Rem = WIDTH - k * Chunk;

        logic [Rem-1:0]           op_a;
        logic [Rem-1:0]           op_b;
        logic                     c_in;
        logic                     v_in;
        logic [Chunk:0]           sum;
        logic [(k+1)*Chunk-1:0]   res_d;
        logic [(k+1)*Chunk-1:0]   res_q;
        logic                     cy_q;
        logic                     vld_q;

        if (k == 0) begin : g_first
            assign op_a  = a;
            assign op_b  = b_eff;
            assign c_in  = c0;
            assign v_in  = in_valid;
            assign res_d = sum[Chunk-1:0];
        end else begin : g_next
            assign op_a  = g_stage[k-1].g_fwd.rem_a_q;
            assign op_b  = g_stage[k-1].g_fwd.rem_b_q;
            assign c_in  = g_stage[k-1].cy_q;
            assign v_in  = g_stage[k-1].vld_q;
            assign res_d = {sum[Chunk-1:0], g_stage[k-1].res_q};
        end

        assign sum = {1'b0, op_a[Chunk-1:0]} + {1'b0, op_b[Chunk-1:0]} + {{Chunk{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                res_q <= '0;
            end else if (advance) begin
                vld_q <= v_in;
                cy_q  <= sum[Chunk];
                res_q <= res_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [Rem-Chunk-1:0] rem_a_q;
            logic [Rem-Chunk-1:0] rem_b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_a_q <= '0;
                    rem_b_q <= '0;
                end else if (advance) begin
                    rem_a_q <= op_a[Rem-1:Chunk];
                    rem_b_q <= op_b[Rem-1:Chunk];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // op_a/op_b MSBs here are the skew-delayed operand sign bits
            assign ovf_d = (op_a[Rem-1] == op_b[Rem-1]) && (sum[Chunk-1] != op_a[Rem-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign z         = g_stage[STAGES-1].res_q;
    assign carry     = g_stage[STAGES-1].cy_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on the 4-stage instance, then randomized
// traffic on 1-, 4- and 16-stage instances checked against an arithmetic model.
module tb_pipelined_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         ir [3];
    logic         ov [3];
    logic         cy [3];
    logic         of [3];
    logic [W-1:0] zz [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .z(zz[0]),
        .carry(cy[0]), .ovf(of[0])
    );
    pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .z(zz[1]),
        .carry(cy[1]), .ovf(of[1])
    );
    pipelined_adder #(.WIDTH(16), .STAGES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .z(zz[2]),
        .carry(cy[2]), .ovf(of[2])
    );

    // Expected {ovf, carry, z}
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [15:0] bp;
        logic [16:0] full;
        logic        o;
        bp   = ms ? ~mb : mb;
        full = 17'(ma) + 17'(bp) + 17'(ms ? 1'b1 : mc);
        o    = (ma[15] == bp[15]) && (full[15] != ma[15]);
        return {o, full};
    endfunction

    // Sends one op on the 4-stage DUT; lat = negedges until out_valid (0 on timeout)
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic ts, output logic [17:0] res, output int lat);
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        res = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ov[0]) begin
                lat = i;
                res = {of[0], cy[0], zz[0]};
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        #12;
        n_checks++;
        if (ov[0] !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov[0]);
        else n_pass++;
        n_checks++;
        if ({of[0], cy[0], zz[0]} !== 18'h0)
            $display("FAIL reset_outputs: got %h expected 00000", {of[0], cy[0], zz[0]});
        else n_pass++;
        n_checks++;
        if (ov[1] !== 1'b0 || ov[2] !== 1'b0)
            $display("FAIL reset_other_valid: got %b%b expected 00", ov[1], ov[2]);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ir[0] !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", ir[0]);
        else n_pass++;
    endtask

    task automatic test_carry_chain;
        logic [17:0] res;
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== 18'h10000) $display("FAIL carry_chain: got %h expected 10000", res);
        else n_pass++;
        n_checks++;
        if (lat !== 4) $display("FAIL carry_chain_latency: got %0d expected 4", lat);
        else n_pass++;
    endtask

    task automatic test_overflow;
        logic [17:0] res;
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== 18'h28000) $display("FAIL ovf_pos: got %h expected 28000", res);
        else n_pass++;
        run_op(16'h8000, 16'hFFFF, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== 18'h37FFF) $display("FAIL ovf_neg: got %h expected 37fff", res);
        else n_pass++;
    endtask

    task automatic test_subtract;
        logic [17:0] res;
        int lat;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, res, lat);
        n_checks++;
        if (res !== 18'h0FFFE) $display("FAIL sub_borrow: got %h expected 0fffe", res);
        else n_pass++;
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, res, lat);
        n_checks++;
        if (res !== 18'h10002) $display("FAIL sub_no_borrow: got %h expected 10002", res);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] oa [8];
        logic [15:0] ob [8];
        logic        oc [8];
        logic        os [8];
        logic [17:0] expq [$];
        logic [17:0] held;
        logic [17:0] exp_v;
        int idx = 0;
        int emitted = 0;
        for (int i = 0; i < 8; i++) begin
            oa[i] = 16'($urandom); ob[i] = 16'($urandom);
            oc[i] = 1'($urandom); os[i] = 1'($urandom);
            expq.push_back(model(oa[i], ob[i], oc[i], os[i]));
        end
        held = '0;
        for (int cyc = 0; cyc < 60 && emitted < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (idx < 8) begin
                a = oa[idx]; b = ob[idx]; cin = oc[idx]; sub = os[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 5 && cyc <= 7) begin
                n_checks++;
                if (ir[0] !== 1'b0 || ov[0] !== 1'b1)
                    $display("FAIL stall_ready cyc%0d: in_ready=%b out_valid=%b expected 0/1",
                             cyc, ir[0], ov[0]);
                else n_pass++;
                if (cyc == 5) held = {of[0], cy[0], zz[0]};
                else begin
                    n_checks++;
                    if ({of[0], cy[0], zz[0]} !== held)
                        $display("FAIL stall_hold cyc%0d: got %h expected %h",
                                 cyc, {of[0], cy[0], zz[0]}, held);
                    else n_pass++;
                end
            end
            if (ov[0] && out_ready) begin
                exp_v = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
                n_checks++;
                if ({of[0], cy[0], zz[0]} !== exp_v)
                    $display("FAIL b2b_result #%0d: got %h expected %h",
                             emitted, {of[0], cy[0], zz[0]}, exp_v);
                else n_pass++;
                emitted++;
            end
            if (in_valid && ir[0]) idx++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (emitted !== 8 || idx !== 8)
            $display("FAIL b2b_count: emitted %0d accepted %0d expected 8/8", emitted, idx);
        else n_pass++;
    endtask

    task automatic test_reset_flush;
        logic [17:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom); cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1; out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ov[0] !== 1'b1) $display("FAIL flush_pre_valid: got %b expected 1", ov[0]);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ov[0] !== 1'b0 || zz[0] !== 16'h0)
            $display("FAIL flush_async: out_valid=%b z=%h expected 0/0000", ov[0], zz[0]);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(16'h1234, 16'h1111, 1'b1, 1'b0, res, lat);
        n_checks++;
        if (lat !== 4 || res !== 18'h02346)
            $display("FAIL flush_new_op: lat %0d res %h expected 4 02346", lat, res);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [17:0] q0 [$];
        logic [17:0] q1 [$];
        logic [17:0] q2 [$];
        logic [17:0] m;
        logic [17:0] exp_v;
        logic [17:0] got;
        bit          have;
        int          shown = 0;
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 20060; cyc++) begin
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            if (cyc < 20000) begin
                in_valid  = ($urandom % 4) != 0;
                out_ready = ($urandom % 4) != 0;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            m = model(a, b, cin, sub);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && out_ready) begin
                    got  = {of[d], cy[d], zz[d]};
                    have = 1'b0;
                    exp_v = '0;
                    case (d)
                        0: if (q0.size() > 0) begin exp_v = q0.pop_front(); have = 1'b1; end
                        1: if (q1.size() > 0) begin exp_v = q1.pop_front(); have = 1'b1; end
                        default: if (q2.size() > 0) begin exp_v = q2.pop_front(); have = 1'b1; end
                    endcase
                    n_checks++;
                    if (have && got === exp_v) n_pass++;
                    else if (shown < 20) begin
                        shown++;
                        $display("FAIL random dut%0d cyc%0d: got %h expected %h (queued=%0d)",
                                 d, cyc, got, exp_v, have);
                    end
                end
                if (in_valid && ir[d]) begin
                    case (d)
                        0: q0.push_back(m);
                        1: q1.push_back(m);
                        default: q2.push_back(m);
                    endcase
                end
            end
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0)
            $display("FAIL random_drain: left %0d/%0d/%0d expected 0/0/0",
                     q0.size(), q1.size(), q2.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
